// File: rtl/game_state_ctrl.sv
// game_state_ctrl -- match sequencing for a two-player paddle game.
//
// Walks IDLE -> SERVE -> PLAY -> SCORED -> (SERVE | OVER), keeps both scores,
// and drives the overlay/motion enables for the video and physics logic.
//
// Ports
//   clk_0       system/pixel clock, everything on its rising edge
//   rst         synchronous reset, active low
//   frame_tick  one-cycle pulse per video frame
//   any_key     level, high while any player key is held
//   miss_l      pulse: ball left through the left edge (right player scores)
//   miss_r      pulse: ball left through the right edge (left player scores)
//   show_title  title overlay enable
//   show_over   "Game over!" overlay enable
//   show_start  blinking "Press any key to start" overlay enable
//   ball_reset  hold ball at centre
//   play_en     paddle/ball motion enable
//   score_l/r   player scores, saturating at WIN_SCORE
//   winner      0 = left won, 1 = right won; valid while show_over = 1
module game_state_ctrl #(
  parameter int unsigned WIN_SCORE      = 7,
  parameter int unsigned SERVE_FRAMES   = 60,
  parameter int unsigned BLINK_FRAMES   = 30,
  parameter int unsigned LOCKOUT_FRAMES = 90
) (
  input  logic       clk_0,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       any_key,
  input  logic       miss_l,
  input  logic       miss_r,
  output logic       show_title,
  output logic       show_over,
  output logic       show_start,
  output logic       ball_reset,
  output logic       play_en,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic       winner
);

  localparam int unsigned FMAX = (SERVE_FRAMES > LOCKOUT_FRAMES) ? SERVE_FRAMES : LOCKOUT_FRAMES;
  localparam int unsigned FW   = $clog2(FMAX + 1);
  localparam int unsigned BW   = $clog2(BLINK_FRAMES + 1);

  localparam logic [3:0]    WIN   = 4'(WIN_SCORE);
  localparam logic [FW-1:0] SERVE_N = FW'(SERVE_FRAMES);
  localparam logic [FW-1:0] LOCK_N  = FW'(LOCKOUT_FRAMES);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  typedef enum logic [2:0] {
    IDLE,
    SERVE,
    PLAY,
    SCORED,
    OVER
  } state_t;

  state_t        state_q, state_d;
  logic          key_q;
  logic [FW-1:0] fcnt_q, fcnt_d;     // serve delay / game-over lockout
  logic          lock_q, lock_d;     // lockout expired while in OVER
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          bph_q, bph_d;
  logic [3:0]    score_l_d, score_r_d;
  logic          winner_d;
  logic          key_ev;

  logic show_title_d, show_over_d, show_start_d, ball_reset_d, play_en_d;

  // key_q resets to 1 so a key held through reset does not count as a press
  assign key_ev = any_key & ~key_q;

  always_comb begin
    state_d   = state_q;
    fcnt_d    = fcnt_q;
    lock_d    = lock_q;
    bcnt_d    = bcnt_q;
    bph_d     = bph_q;
    score_l_d = score_l;
    score_r_d = score_r;
    winner_d  = winner;

    unique case (state_q)
      IDLE: begin
        // a key event wins over a same-cycle tick: the blink does not advance
        if (key_ev) begin
          state_d   = SERVE;
          fcnt_d    = '0;
          score_l_d = '0;
          score_r_d = '0;
        end else if (frame_tick) begin
          if (bcnt_q == BLINK_LAST) begin
            bcnt_d = '0;
            bph_d  = ~bph_q;
          end else begin
            bcnt_d = bcnt_q + BW'(1);
          end
        end
      end

      SERVE: begin
        if (frame_tick) begin
          fcnt_d = fcnt_q + FW'(1);
          if (fcnt_q + FW'(1) == SERVE_N) begin
            state_d = PLAY;
          end
        end
      end

      PLAY: begin
        // left miss has priority when both edges report in the same cycle
        if (miss_l) begin
          state_d   = SCORED;
          score_r_d = (score_r < WIN) ? score_r + 4'd1 : score_r;
        end else if (miss_r) begin
          state_d   = SCORED;
          score_l_d = (score_l < WIN) ? score_l + 4'd1 : score_l;
        end
      end

      SCORED: begin
        fcnt_d = '0;
        if ((score_l == WIN) || (score_r == WIN)) begin
          state_d  = OVER;
          lock_d   = 1'b0;
          winner_d = (score_r == WIN);
        end else begin
          state_d = SERVE;
        end
      end

      OVER: begin
        if (!lock_q) begin
          if (frame_tick) begin
            fcnt_d = fcnt_q + FW'(1);
            if (fcnt_q + FW'(1) == LOCK_N) begin
              lock_d = 1'b1;
              bcnt_d = '0;
              bph_d  = 1'b1;
            end
          end
        end else if (key_ev) begin
          state_d   = SERVE;
          fcnt_d    = '0;
          lock_d    = 1'b0;
          score_l_d = '0;
          score_r_d = '0;
        end else if (frame_tick) begin
          if (bcnt_q == BLINK_LAST) begin
            bcnt_d = '0;
            bph_d  = ~bph_q;
          end else begin
            bcnt_d = bcnt_q + BW'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase

    // outputs are decoded from the next state so the registers track the state
    show_title_d = (state_d == IDLE);
    show_over_d  = (state_d == OVER);
    ball_reset_d = (state_d != PLAY);
    play_en_d    = (state_d == PLAY);
    show_start_d = ((state_d == IDLE) || ((state_d == OVER) && lock_d)) ? bph_d : 1'b0;
  end

  always_ff @(posedge clk_0) begin
    if (!rst) begin
      state_q    <= IDLE;
      key_q      <= 1'b1;
      fcnt_q     <= '0;
      lock_q     <= 1'b0;
      bcnt_q     <= '0;
      bph_q      <= 1'b1;
      score_l    <= '0;
      score_r    <= '0;
      winner     <= 1'b0;
      show_title <= 1'b1;
      show_over  <= 1'b0;
      show_start <= 1'b0;
      ball_reset <= 1'b1;
      play_en    <= 1'b0;
    end else begin
      state_q    <= state_d;
      key_q      <= any_key;
      fcnt_q     <= fcnt_d;
      lock_q     <= lock_d;
      bcnt_q     <= bcnt_d;
      bph_q      <= bph_d;
      score_l    <= score_l_d;
      score_r    <= score_r_d;
      winner     <= winner_d;
      show_title <= show_title_d;
      show_over  <= show_over_d;
      show_start <= show_start_d;
      ball_reset <= ball_reset_d;
      play_en    <= play_en_d;
    end
  end

endmodule

// File: tb/tb_game_state_ctrl.sv
module tb_game_state_ctrl;

  logic       clk_0 = 1'b0;
  logic       rst = 1'b0;
  logic       frame_tick = 1'b0;
  logic       any_key = 1'b0;
  logic       miss_l = 1'b0;
  logic       miss_r = 1'b0;
  logic       show_title, show_over, show_start, ball_reset, play_en, winner;
  logic [3:0] score_l, score_r;

  int checks = 0;
  int errors = 0;

  always #5 clk_0 = ~clk_0;

  game_state_ctrl #(
    .WIN_SCORE(7),
    .SERVE_FRAMES(60),
    .BLINK_FRAMES(30),
    .LOCKOUT_FRAMES(90)
  ) dut (
    .clk_0(clk_0),
    .rst(rst),
    .frame_tick(frame_tick),
    .any_key(any_key),
    .miss_l(miss_l),
    .miss_r(miss_r),
    .show_title(show_title),
    .show_over(show_over),
    .show_start(show_start),
    .ball_reset(ball_reset),
    .play_en(play_en),
    .score_l(score_l),
    .score_r(score_r),
    .winner(winner)
  );

  typedef struct {
    logic       key, tick, ml, mr;
    logic       title, over, start, br, pe;
    logic [3:0] sl, sr;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic t, o, s, b, p,
                         input logic [3:0] sl, sr);
    chk({name, ".show_title"}, int'(show_title), int'(t));
    chk({name, ".show_over"},  int'(show_over),  int'(o));
    chk({name, ".show_start"}, int'(show_start), int'(s));
    chk({name, ".ball_reset"}, int'(ball_reset), int'(b));
    chk({name, ".play_en"},    int'(play_en),    int'(p));
    chk({name, ".score_l"},    int'(score_l),    int'(sl));
    chk({name, ".score_r"},    int'(score_r),    int'(sr));
  endtask

  // one clock with the given inputs; pulses drop right after the edge
  task automatic cyc(input logic k, t, ml, mr);
    any_key = k; frame_tick = t; miss_l = ml; miss_r = mr;
    @(posedge clk_0); #1;
    frame_tick = 1'b0; miss_l = 1'b0; miss_r = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(any_key, 1'b1, 1'b0, 1'b0);
  endtask

  // from SERVE: wait out the serve delay, then one miss and the SCORED cycle
  task automatic point(input logic left_scores);
    ticks(60);
    chk("serve_to_play.play_en", int'(play_en), 1);
    cyc(1'b0, 1'b0, ~left_scores, left_scores);
    chk("scored.play_en", int'(play_en), 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //        key  tick ml   mr   title over start br  pe  sl    sr
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0}; // held through reset
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0}; // release + tick
    vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0}; // press + tick -> SERVE
    vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0}; // serve tick 1
    vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0}; // misses ignored
    vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0};

    // reset with a key held
    rst = 1'b0;
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    chk_all("reset", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
    chk("reset.winner", int'(winner), 0);
    rst = 1'b1;

    for (int i = 0; i < 7; i++) begin
      cyc(vecs[i].key, vecs[i].tick, vecs[i].ml, vecs[i].mr);
      chk_all($sformatf("vec%0d", i), vecs[i].title, vecs[i].over, vecs[i].start,
              vecs[i].br, vecs[i].pe, vecs[i].sl, vecs[i].sr);
    end

    // serve delay: one tick already counted, 58 more -> still held
    ticks(58);
    chk("serve59.play_en", int'(play_en), 0);
    ticks(1);
    chk_all("serve60", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0);

    // both edges in one cycle: left miss wins
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    chk_all("dual_miss", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk_all("dual_miss_serve", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd1);

    // left wins 7 points
    for (int i = 0; i < 7; i++) point(1'b1);
    chk_all("left_win", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd7, 4'd1);
    chk("left_win.winner", int'(winner), 0);

    // lockout: key during lockout ignored, misses ignored
    ticks(10);
    cyc(1'b1, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk_all("lock_key", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd7, 4'd1);
    ticks(79);
    chk("lock89.show_start", int'(show_start), 0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("lock89_key.show_over", int'(show_over), 1);
    ticks(1);
    chk("lock90.show_start", int'(show_start), 1);
    ticks(29);
    chk("over_blink29", int'(show_start), 1);
    ticks(1);
    chk("over_blink30", int'(show_start), 0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk_all("over_to_serve", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
    chk("over_to_serve.winner_hold", int'(winner), 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);

    // right wins 7 points
    for (int i = 0; i < 7; i++) point(1'b0);
    chk_all("right_win", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 4'd7);
    chk("right_win.winner", int'(winner), 1);
    ticks(90);
    chk("right_lock.show_start", int'(show_start), 1);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    chk_all("right_restart", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
    chk("right_restart.winner_hold", int'(winner), 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);

    // reach 3/5, enter PLAY, then reset
    for (int i = 0; i < 3; i++) point(1'b1);
    for (int i = 0; i < 5; i++) point(1'b0);
    ticks(60);
    chk_all("play_3_5", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 4'd5);
    rst = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk_all("mid_reset", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
    chk("mid_reset.winner", int'(winner), 0);
    rst = 1'b1;

    // idle blink: 1 for ticks 0..29, 0 for 30..59, 1 at 60
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk("idle_blink0", int'(show_start), 1);
    ticks(29);
    chk("idle_blink29", int'(show_start), 1);
    ticks(1);
    chk("idle_blink30", int'(show_start), 0);
    ticks(29);
    chk("idle_blink59", int'(show_start), 0);
    ticks(1);
    chk("idle_blink60", int'(show_start), 1);
    chk("idle_blink60.show_title", int'(show_title), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/game_state_ctrl.md
GAME_STATE_CTRL -- requirements
Module: game_state_ctrl

Interface
REQ-001 Parameter WIN_SCORE, default 7, points that end a match (1..15).
REQ-002 Parameter SERVE_FRAMES, default 60, frames spent in SERVE before play resumes (>=1).
REQ-003 Parameter BLINK_FRAMES, default 30, frames per half-period of the start-prompt blink (>=1).
REQ-004 Parameter LOCKOUT_FRAMES, default 90, frames after game over during which keys are ignored (>=1).
REQ-005 clk_0  in  1  single system/pixel clock; all logic on posedge clk_0.
REQ-006 rst  in  1  reset, synchronous, active-low (asserted when 0).
REQ-007 frame_tick  in  1  one-cycle pulse per video frame.
REQ-008 any_key  in  1  level, 1 while any player key is held.
REQ-009 miss_l  in  1  one-cycle pulse, ball passed the left edge, so the right player scores.
REQ-010 miss_r  in  1  one-cycle pulse, ball passed the right edge, so the left player scores.
REQ-011 show_title  out  1  title overlay enable.
REQ-012 show_over  out  1  "Game over!" overlay enable.
REQ-013 show_start  out  1  "Press any key to start" overlay enable (blinking).
REQ-014 ball_reset  out  1  hold ball at centre.
REQ-015 play_en  out  1  paddle/ball motion enable.
REQ-016 score_l, score_r  out  4 each  player scores.
REQ-017 winner  out  1  0 = left won, 1 = right won; valid while show_over=1.

Function
REQ-018 The FSM SHALL have exactly five states: IDLE, SERVE, PLAY, SCORED, OVER.
REQ-019 Key press event = rising edge of any_key: registered any_key was 0 and current any_key is 1; the edge register SHALL reset to 1, so a key held through reset produces no event.
REQ-020 IDLE: show_title=1, ball_reset=1; on key event -> SERVE, score_l=score_r=0.
REQ-021 SERVE: ball_reset=1, play_en=0; the frame counter SHALL clear on entry and increment on frame_tick; on the tick that brings it to SERVE_FRAMES -> PLAY.
REQ-022 PLAY: play_en=1; miss_l -> score_r+1; miss_r -> score_l+1; either -> SCORED next cycle.
REQ-023 Simultaneous miss_l and miss_r in PLAY: miss_l SHALL take priority; only score_r increments.
REQ-024 miss_l/miss_r outside PLAY SHALL be ignored.
REQ-025 SCORED, exactly one cycle: if score_l or score_r equals WIN_SCORE -> OVER and latch winner; else -> SERVE.
REQ-026 Scores SHALL saturate at WIN_SCORE and never wrap.
REQ-027 OVER: show_over=1, ball_reset=1, play_en=0; key events SHALL be ignored until LOCKOUT_FRAMES frame_ticks have been counted since entry.
REQ-028 OVER after lockout: key event -> SERVE with both scores cleared; winner SHALL hold its value until the next OVER.
REQ-029 Blink: a separate frame counter and phase bit; both SHALL clear to phase=1 on entry to IDLE and on lockout expiry; phase toggles every BLINK_FRAMES frame_ticks.
REQ-030 show_start SHALL equal the blink phase in IDLE, and in OVER after lockout expiry; it SHALL be 0 otherwise.
REQ-031 All outputs SHALL be registered and reflect the new state one cycle after the transition.
REQ-032 A key event and frame_tick in the same cycle: the key event SHALL take effect, and the tick SHALL not advance the counter of the left state.

Reset
REQ-033 While rst=0 at a clock edge: state=IDLE, show_title=1, ball_reset=1, all other outputs 0, scores 0, winner 0, all counters 0, blink phase 1.
REQ-034 Reset asserted mid-operation (any state) SHALL return to the REQ-033 values on the next edge; no partial score is retained.

Verification
REQ-035 Reset, then hold any_key=1 -> stays IDLE, show_title=1; release and press again -> SERVE, scores 0/0.
REQ-036 In SERVE with SERVE_FRAMES=60, apply 59 ticks -> play_en=0; 60th tick -> play_en=1 one cycle later.
REQ-037 In PLAY, pulse miss_l and miss_r in the same cycle -> score_r=1, score_l=0, SCORED then SERVE.
REQ-038 Left scores 7 times (WIN_SCORE=7) -> score_l=7, OVER, show_over=1, winner=0; a key event within 90 ticks is ignored, and after the 90th tick show_start=1 and a key event -> SERVE, scores 0/0.
REQ-039 In IDLE with BLINK_FRAMES=30 -> show_start=1 for ticks 0..29, 0 for ticks 30..59, 1 again at tick 60.
REQ-040 Assert rst=0 during PLAY with score 3/5 -> next edge IDLE, scores 0/0, play_en=0.
